// File: rtl/nat_pkg.sv
// nat_pkg: shared constants, tuple layout and FSM encoding for the forward and reverse NAT blocks
package nat_pkg;
  localparam int ID_W = 16;
  localparam int TUPLE_W = 104;
  localparam int CNT_W = 32;
  localparam int TUP_SRC_IP_LSB = 72;
  localparam int TUP_DST_IP_LSB = 40;
  localparam int TUP_SRC_PORT_LSB = 24;
  localparam int TUP_DST_PORT_LSB = 8;
  localparam int TUP_PROTO_LSB = 0;
  localparam logic [7:0] ETHERTYPE_IPV4_HI = 8'h08;
  localparam logic [7:0] ETHERTYPE_IPV4_LO = 8'h00;
  localparam logic [7:0] PROTO_TCP = 8'h06;
  localparam logic [2:0] ETH_BEAT = 3'd1;
  localparam logic [2:0] PROTO_BEAT = 3'd2;
  localparam logic [2:0] IP_BEAT = 3'd3;
  localparam logic [2:0] PORT_BEAT = 3'd4;
  localparam logic [2:0] BEAT_SAT = 3'd5;
  typedef enum logic [1:0] {ST_PASS, ST_LOOKUP, ST_WAIT} nat_state_t;
  function automatic logic [31:0] tuple_src_ip(input logic [TUPLE_W-1:0] t);
    return t[TUP_SRC_IP_LSB +: 32];
  endfunction
  function automatic logic [31:0] tuple_dst_ip(input logic [TUPLE_W-1:0] t);
    return t[TUP_DST_IP_LSB +: 32];
  endfunction
  function automatic logic [15:0] tuple_src_port(input logic [TUPLE_W-1:0] t);
    return t[TUP_SRC_PORT_LSB +: 16];
  endfunction
  function automatic logic [15:0] tuple_dst_port(input logic [TUPLE_W-1:0] t);
    return t[TUP_DST_PORT_LSB +: 16];
  endfunction
  function automatic logic [7:0] tuple_proto(input logic [TUPLE_W-1:0] t);
    return t[TUP_PROTO_LSB +: 8];
  endfunction
endpackage

// File: rtl/nat_reverse_lookup.sv
// nat_reverse_lookup: restores the original TCP port on return traffic from the forward NAT conn table
module nat_reverse_lookup #(
  parameter int ID_W = nat_pkg::ID_W,
  parameter int TUPLE_W = nat_pkg::TUPLE_W,
  parameter int CNT_W = nat_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        s_axis_tdata,
  input  logic [7:0]         s_axis_tkeep,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [63:0]        m_axis_tdata,
  output logic [7:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               tbl_rd_en,
  output logic [ID_W-1:0]    tbl_rd_addr,
  input  logic [TUPLE_W-1:0] tbl_rd_data,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);
  import nat_pkg::*;
  nat_state_t state, state_nxt;
  logic [2:0] beat_idx;
  logic is_ip;
  logic [7:0] proto;
  logic [31:0] pkt_src_ip;
  logic accept, start, resolve, hit;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign start = accept && beat_idx == PORT_BEAT && is_ip && proto == PROTO_TCP;
  // the read strobe is issued from LOOKUP, so the entry lands once it has dropped again in WAIT
  assign resolve = state == ST_WAIT && !tbl_rd_en;
  assign hit = |tbl_rd_data && tuple_proto(tbl_rd_data) == PROTO_TCP && tuple_dst_ip(tbl_rd_data) == pkt_src_ip;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_PASS;
    else state <= state_nxt;
  always_comb
    state_nxt = state == ST_PASS ? (start ? ST_LOOKUP : ST_PASS) :
                state == ST_LOOKUP ? ST_WAIT :
                resolve ? ST_PASS : ST_WAIT;
  always_comb
    s_axis_tready = state == ST_PASS && (!m_axis_tvalid || m_axis_tready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_idx <= '0;
      is_ip <= 1'b0;
      proto <= '0;
      pkt_src_ip <= '0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
      tbl_rd_en <= 1'b0;
      tbl_rd_addr <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      tbl_rd_en <= state == ST_LOOKUP;
      if (start) tbl_rd_addr <= s_axis_tdata[16 +: ID_W];
      if (accept) begin
        beat_idx <= s_axis_tlast ? 3'd0 : beat_idx == BEAT_SAT ? BEAT_SAT : beat_idx + 3'd1;
        if (beat_idx == ETH_BEAT) is_ip <= s_axis_tdata[39:32] == ETHERTYPE_IPV4_HI && s_axis_tdata[47:40] == ETHERTYPE_IPV4_LO;
        if (beat_idx == PROTO_BEAT) proto <= s_axis_tdata[63:56];
        if (beat_idx == IP_BEAT) pkt_src_ip <= s_axis_tdata[47:16];
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tvalid <= !start;
      end else if (resolve) begin
        m_axis_tvalid <= 1'b1;
        if (hit) m_axis_tdata[31:16] <= tuple_dst_port(tbl_rd_data);
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (resolve && hit) hit_cnt <= hit_cnt + CNT_W'(1);
      if (resolve && !hit) miss_cnt <= miss_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_nat_reverse_lookup.sv
// tb_nat_reverse_lookup: vector table, hand sequences and randomized packets against a per-packet model
module tb_nat_reverse_lookup;
  typedef struct { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;
  typedef struct {
    int nb; logic [15:0] et; logic [7:0] pr; logic [31:0] sip; logic [15:0] cid;
    logic [103:0] entry; int h; int m; int port; int stall;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0] s_axis_tkeep = '0;
  logic s_axis_tlast = 0, s_axis_tvalid = 0, s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid;
  logic m_axis_tready = 1;
  logic tbl_rd_en;
  logic [15:0] tbl_rd_addr;
  logic [103:0] tbl_rd_data = '0;
  logic [31:0] hit_cnt, miss_cnt;
  nat_reverse_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr), .tbl_rd_data(tbl_rd_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  logic [103:0] tbl [logic [15:0]];
  beat_t outq[$];
  beat_t last_out[$];
  int total = 0, bad = 0, rd_pulses = 0;
  int exp_hit = 0, exp_miss = 0;
  logic [15:0] last_addr = '0;
  bit bp_en = 0;
  function automatic logic [103:0] tbl_get(input logic [15:0] a);
    return tbl.exists(a) ? tbl[a] : 104'd0;
  endfunction
  // table RAM: entry valid exactly one cycle after the strobe, junk otherwise
  always @(posedge clk)
    tbl_rd_data <= tbl_rd_en ? tbl_get(tbl_rd_addr) : {$urandom, $urandom, $urandom, 8'($urandom)};
  always @(negedge clk)
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) outq.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
      if (tbl_rd_en) begin
        rd_pulses++;
        last_addr = tbl_rd_addr;
      end
    end
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) m_axis_tready = $urandom_range(0, 3) != 0;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void make_pkt(input int nb, input logic [15:0] et, input logic [7:0] pr,
                                   input logic [31:0] sip, input logic [15:0] cid, output beat_t pkt[$]);
    pkt = {};
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.last = i == nb - 1;
      if (i == 1) begin
        b.data[39:32] = et[15:8];
        b.data[47:40] = et[7:0];
      end
      if (i == 2) b.data[63:56] = pr;
      if (i == 3) b.data[47:16] = sip;
      if (i == 4) b.data[31:16] = cid;
      pkt.push_back(b);
    end
  endfunction
  // packet-level reference: only the fifth beat of an IPv4/TCP packet may change
  function automatic void model(input beat_t pkt[$], output beat_t exp[$], output int h, output int m,
                                output int lk, output logic [15:0] id);
    logic [103:0] e;
    beat_t b;
    exp = pkt;
    h = 0; m = 0; lk = 0; id = '0;
    if (pkt.size() < 5) return;
    if (pkt[1].data[39:32] != 8'h08 || pkt[1].data[47:40] != 8'h00 || pkt[2].data[63:56] != 8'h06) return;
    lk = 1;
    id = pkt[4].data[31:16];
    e = tbl_get(id);
    if (e != 0 && e[7:0] == 8'h06 && e[71:40] == pkt[3].data[47:16]) begin
      h = 1;
      b = exp[4];
      b.data[31:16] = e[23:8];
      exp[4] = b;
    end else m = 1;
  endfunction
  task automatic send_beat(input beat_t b, output int stalls);
    int n = 0;
    s_axis_tdata = b.data;
    s_axis_tkeep = b.keep;
    s_axis_tlast = b.last;
    s_axis_tvalid = 1;
    @(negedge clk);
    while (!s_axis_tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      total++;
      bad++;
      $display("FAIL s_ready_timeout: input beat not accepted within %0d cycles", n);
    end
    stalls = n;
    @(posedge clk);
    #1;
    s_axis_tvalid = 0;
  endtask
  task automatic run_pkt(input beat_t pkt[$], output int h, output int m, output int stall5);
    beat_t expq[$];
    logic [15:0] id;
    int rd0, st, n, lk;
    model(pkt, expq, h, m, lk, id);
    rd0 = rd_pulses;
    stall5 = -1;
    n = 0;
    foreach (pkt[i]) begin
      send_beat(pkt[i], st);
      if (i == 5) stall5 = st;
    end
    while (outq.size() < expq.size() && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("out_count", 128'(outq.size()), 128'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("beat%0d", i), 128'({outq[i].data, outq[i].keep, outq[i].last}),
            128'({expq[i].data, expq[i].keep, expq[i].last}));
    check("rd_pulses", 128'(rd_pulses - rd0), 128'(lk));
    if (lk != 0) check("rd_addr", 128'(last_addr), 128'(id));
    last_out = outq;
    outq.delete();
  endtask
  initial begin
    vec_t vecs[10];
    beat_t pkt[$];
    int h, m, st, n;
    logic [103:0] e_hit, e;
    logic [15:0] gp, cid;
    logic [15:0] ids[4];
    logic [31:0] sip;
    e_hit = {32'hC0A80001, 32'h0A000002, 16'h1234, 16'h0050, 8'h06};
    vecs[0] = '{6, 16'h86DD, 8'h06, 32'h0A000002, 16'h1234, e_hit, 0, 0, 'h1234, 0};
    vecs[1] = '{6, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, e_hit, 1, 0, 'h0050, 3};
    vecs[2] = '{6, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, 104'd0, 0, 1, 'h1234, 3};
    vecs[3] = '{6, 16'h0800, 8'h06, 32'h0A000002, 16'h1234,
                {32'hC0A80001, 32'h0A000003, 16'h1234, 16'h0050, 8'h06}, 0, 1, 'h1234, 3};
    vecs[4] = '{6, 16'h0800, 8'h11, 32'h0A000002, 16'h1234, e_hit, 0, 0, 'h1234, 0};
    vecs[5] = '{4, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, e_hit, 0, 0, -1, -1};
    vecs[6] = '{5, 16'h0800, 8'h06, 32'h0A000002, 16'h0077,
                {32'h01020304, 32'h0A000002, 16'h0077, 16'h1F90, 8'h06}, 1, 0, 'h1F90, -1};
    vecs[7] = '{8, 16'h0800, 8'h06, 32'hAC100005, 16'hFFFF,
                {32'h00000000, 32'hAC100005, 16'hFFFF, 16'h01BB, 8'h06}, 1, 0, 'h01BB, 3};
    vecs[8] = '{6, 16'h0800, 8'h06, 32'h0A000002, 16'h0100,
                {32'hC0A80001, 32'h0A000002, 16'h0100, 16'h0050, 8'h11}, 0, 1, 'h0100, 3};
    vecs[9] = '{1, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, e_hit, 0, 0, -1, -1};
    #1;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
    check("rst_rd_en", 128'(tbl_rd_en), 128'(0));
    check("rst_rd_addr", 128'(tbl_rd_addr), 128'(0));
    check("rst_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
    check("rst_s_ready", 128'(s_axis_tready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      tbl[vecs[k].cid] = vecs[k].entry;
      make_pkt(vecs[k].nb, vecs[k].et, vecs[k].pr, vecs[k].sip, vecs[k].cid, pkt);
      run_pkt(pkt, h, m, st);
      exp_hit += vecs[k].h;
      exp_miss += vecs[k].m;
      check($sformatf("v%0d_hit_cnt", k), 128'(hit_cnt), 128'(exp_hit));
      check($sformatf("v%0d_miss_cnt", k), 128'(miss_cnt), 128'(exp_miss));
      if (vecs[k].port >= 0) begin
        gp = last_out.size() > 4 ? last_out[4].data[31:16] : 16'hxxxx;
        check($sformatf("v%0d_port", k), 128'(gp), 128'(vecs[k].port));
      end
      if (vecs[k].stall >= 0) check($sformatf("v%0d_stall", k), 128'(st), 128'(vecs[k].stall));
    end
    tbl[16'h0042] = {32'h11111111, 32'h0A000009, 16'h0042, 16'h0016, 8'h06};
    make_pkt(7, 16'h0800, 8'h06, 32'h0A000009, 16'h0042, pkt);
    fork
      run_pkt(pkt, h, m, st);
      begin
        n = 0;
        @(negedge clk);
        while (!tbl_rd_en && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_rd_seen", 128'(tbl_rd_en), 128'(1));
        #1 m_axis_tready = 0;
        repeat (5) @(posedge clk);
        #1 m_axis_tready = 1;
      end
    join
    exp_hit += 1;
    check("bp_hit_cnt", 128'(hit_cnt), 128'(exp_hit));
    gp = last_out.size() > 4 ? last_out[4].data[31:16] : 16'hxxxx;
    check("bp_port", 128'(gp), 128'(16'h0016));
    tbl[16'h1234] = e_hit;
    make_pkt(6, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, pkt);
    for (int i = 0; i < 5; i++) send_beat(pkt[i], st);
    @(posedge clk);
    #1;
    check("wait_rd_en", 128'(tbl_rd_en), 128'(1));
    rst_n = 0;
    #1;
    check("arst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("arst_rd_en", 128'(tbl_rd_en), 128'(0));
    check("arst_cnts", 128'({hit_cnt, miss_cnt}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    outq.delete();
    exp_hit = 0;
    exp_miss = 0;
    make_pkt(6, 16'h0800, 8'h06, 32'h0A000002, 16'h1234, pkt);
    run_pkt(pkt, h, m, st);
    check("post_rst_hit", 128'(hit_cnt), 128'(1));
    check("post_rst_miss", 128'(miss_cnt), 128'(0));
    gp = last_out.size() > 4 ? last_out[4].data[31:16] : 16'hxxxx;
    check("post_rst_port", 128'(gp), 128'(16'h0050));
    exp_hit = 1;
    ids[0] = 16'h0000; ids[1] = 16'h0001; ids[2] = 16'hABCD; ids[3] = 16'hFFFF;
    bp_en = 1;
    for (int r = 0; r < 40; r++) begin
      cid = ids[$urandom_range(0, 3)];
      sip = $urandom_range(0, 1) != 0 ? 32'h0A000002 : 32'h0A000003;
      n = $urandom_range(0, 3);
      e = n == 0 ? 104'd0 :
          n == 1 ? {$urandom, 32'h0A000002, 16'($urandom), 16'($urandom), 8'h06} :
          n == 2 ? {$urandom, 32'h0A000002, 16'($urandom), 16'($urandom), 8'h11} :
                   {$urandom, $urandom, $urandom, 8'($urandom)};
      tbl[cid] = e;
      make_pkt($urandom_range(1, 8), $urandom_range(0, 3) == 0 ? 16'h86DD : 16'h0800,
               $urandom_range(0, 3) == 0 ? 8'h11 : 8'h06, sip, cid, pkt);
      run_pkt(pkt, h, m, st);
      exp_hit += h;
      exp_miss += m;
      check($sformatf("r%0d_hit_cnt", r), 128'(hit_cnt), 128'(exp_hit));
      check($sformatf("r%0d_miss_cnt", r), 128'(miss_cnt), 128'(exp_miss));
    end
    bp_en = 0;
    m_axis_tready = 1;
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nat_reverse_lookup.md
Name: nat_reverse_lookup

Overview:
- Return-path NAT translator: 64-bit AXI-Stream in/out, sits after the forward NAT block on the server-to-client direction.
- The forward path replaced each TCP flow's dst_port with a 16-bit connection ID (conn-table slot) and stored the 104-bit tuple {src_ip, dst_ip, src_port, dst_port, protocol} at that slot.
- This block reads that ID from the src_port field of returning TCP packets, fetches the tuple through a read port, and restores the original port.
- Non-TCP and non-IP traffic passes through unchanged.

Parameters:
- ID_W, 16, connection-ID width; table depth is 2^ID_W.
- TUPLE_W, 104, tuple width: src_ip[103:72], dst_ip[71:40], src_port[39:24], dst_port[23:8], protocol[7:0].
- CNT_W, 32, width of the hit and miss counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  64  input beat.
- s_axis_tkeep  in  8  input byte enables.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  64  output beat.
- m_axis_tkeep  out  8  output byte enables.
- m_axis_tlast  out  1  output last.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready; backpressure is honoured.
- tbl_rd_en  out  1  table read strobe.
- tbl_rd_addr  out  ID_W  table index.
- tbl_rd_data  in  TUPLE_W  entry; valid exactly 1 cycle after tbl_rd_en.
- hit_cnt  out  CNT_W  translated packets.
- miss_cnt  out  CNT_W  TCP packets whose lookup failed.

Behaviour:
- Reset values: m_axis_tvalid=0, tdata/tkeep/tlast=0, tbl_rd_en=0, tbl_rd_addr=0, both counters 0, beat index 0, FSM=PASS.
- Reset is asynchronous and may arrive mid-lookup: all state is abandoned, and a pending tbl_rd_data is ignored.

Output register and handshakes:
- Single output register.
- s_axis_tready = (state==PASS) && (!m_axis_tvalid || m_axis_tready).
- A beat accepted in PASS is loaded into the output register and m_axis_tvalid is set, except at beat 4 (see below).
- m_axis_tvalid drops when the downstream handshake completes and no new beat loads.

Beat index:
- Counts accepted beats 0..4, then saturates at 5.
- Clears after any accepted beat with tlast=1.

Parse (tdata bit ranges are byte-lane fixed, identical to the forward path):
- Beat 1: is_ip set iff [39:32]==8'h08 and [47:40]==8'h00.
- Beat 2: protocol=[63:56].
- Beat 3: pkt_src_ip=[47:16].
- Beat 4: conn_id=[31:16].

FSM:
- PASS:
  - Beat 4 accepted with is_ip and protocol==6: load the beat into the output register with m_axis_tvalid=0.
  - Drive tbl_rd_en=1 and tbl_rd_addr=conn_id in the next cycle, then go to LOOKUP.
  - Otherwise stay in PASS.
- LOOKUP: tbl_rd_en pulses for exactly 1 cycle; go to WAIT.
- WAIT: tbl_rd_data is valid this cycle. Hit iff all of:
  - entry != 0;
  - entry.protocol==6;
  - entry.dst_ip==pkt_src_ip.
- WAIT on hit: output tdata[31:16] <= entry.dst_port and hit_cnt++.
- WAIT on miss: beat left unchanged and miss_cnt++.
- WAIT exit: set m_axis_tvalid=1 and go to PASS.
- Stall cost: s_axis_tready is low for 3 cycles per TCP packet.

Boundary conditions:
- tlast at or before beat 3: no lookup, no counter change.
- tlast on beat 4 itself: lookup still runs, and tlast=1 is preserved on the rewritten beat.
- Non-IP, or IP with protocol!=6: pure passthrough with 1-cycle latency.
- Beats after 4 pass unmodified.
- m_axis_tready low during LOOKUP/WAIT has no effect; the rewritten beat waits in the register.
- Counters wrap modulo 2^CNT_W.
- The TCP/IP checksum is not updated.
- conn_id 0xFFFF is a legal index.

Decomposition:
- Shared package nat_pkg holds:
  - ID_W and TUPLE_W;
  - tuple field offsets/slices;
  - ETHERTYPE_IPV4 bytes;
  - PROTO_TCP=8'h06;
  - beat indices (ETH_BEAT=1, PROTO_BEAT=2, IP_BEAT=3, PORT_BEAT=4);
  - FSM state encoding.
- The forward block adopts the same package.
- No sub-module is needed; FSM, parser and output register stay in one module.

Test Plan:
- Non-IP packet of 6 beats, ethertype 0x86DD, m_axis_tready=1 -> identical beats out with 1-cycle latency; tbl_rd_en never asserted; counters stay 0.
- TCP packet with conn_id 0x1234, pkt_src_ip 0x0A000002, table[0x1234]={x, 0x0A000002, y, 16'h0050, 8'h06} -> tbl_rd_addr=0x1234 pulsed one cycle; beat 4 [31:16]=0x0050; hit_cnt=1; s_axis_tready low for exactly 3 cycles.
- Same packet but table entry all zero -> beat 4 unchanged; miss_cnt=1, hit_cnt=0.
- Same packet, entry has matching ID but dst_ip 0x0A000003 -> miss_cnt=1, beat unchanged.
- m_axis_tready held low 5 cycles during a hit packet -> no beat lost or duplicated; output order matches input order; rewritten beat 4 appears once.
- rst_n asserted during WAIT -> m_axis_tvalid=0 immediately; after release the next TCP packet translates correctly and counters restart at 0.
